// File: rtl/frag_line_generator.sv
// Bresenham fragment generator: emits one pixel per clock from (x0,y0) along dx/dy/sx/sy.
// Define FRAG_CLIP_EN to qualify frag_valid with the SCREEN_W x SCREEN_H visible area.
module frag_line_generator #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rst_fragment,
    input  logic               start_fragment,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] dx,
    input  logic [COORD_W-1:0] dy,
    input  logic               sx,
    input  logic               sy,
    output logic [COORD_W-1:0] frag_x,
    output logic [COORD_W-1:0] frag_y,
    output logic               frag_valid,
    output logic               frag_gen_finish,
    output logic               busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int EW = COORD_W + 3;
`ifdef FRAG_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam logic [COORD_W:0]   SCREEN_W_L = SCREEN_W[COORD_W:0];
    localparam logic [COORD_W:0]   SCREEN_H_L = SCREEN_H[COORD_W:0];
    localparam logic [COORD_W-1:0] ONE        = 1;

    state_t                    state;
    logic signed [COORD_W+1:0] err;
    logic        [COORD_W-1:0] remaining;

    logic signed [EW-1:0]      e2;
    logic signed [EW-1:0]      dx_e;
    logic signed [EW-1:0]      dy_e;
    logic signed [COORD_W+1:0] dx_w;
    logic signed [COORD_W+1:0] dy_w;
    logic signed [COORD_W+1:0] err_step;
    logic signed [COORD_W+1:0] err_init;
    logic                      step_x;
    logic                      step_y;
    logic        [COORD_W-1:0] x_step;
    logic        [COORD_W-1:0] y_step;
    logic        [COORD_W-1:0] rem_dec;
    logic        [COORD_W-1:0] max_d;
    logic                      ok_init;
    logic                      ok_step;

    // Next-pixel arithmetic; both axis updates share the same e2 sample.
    always_comb begin
        e2       = {err, 1'b0};
        dx_e     = {3'b000, dx};
        dy_e     = {3'b000, dy};
        dx_w     = {2'b00, dx};
        dy_w     = {2'b00, dy};
        step_x   = (e2 > -dy_e);
        step_y   = (e2 < dx_e);
        err_step = err;
        x_step   = frag_x;
        y_step   = frag_y;
        if (step_x) begin
            err_step = err_step - dy_w;
            x_step   = sx ? (frag_x - ONE) : (frag_x + ONE);
        end
        if (step_y) begin
            err_step = err_step + dx_w;
            y_step   = sy ? (frag_y - ONE) : (frag_y + ONE);
        end
        err_init = dx_w - dy_w;
        max_d    = (dx > dy) ? dx : dy;
        rem_dec  = remaining - ONE;
        ok_init  = !CLIP_EN || (({1'b0, x0} < SCREEN_W_L) && ({1'b0, y0} < SCREEN_H_L));
        ok_step  = !CLIP_EN || (({1'b0, x_step} < SCREEN_W_L) && ({1'b0, y_step} < SCREEN_H_L));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            frag_x          <= '0;
            frag_y          <= '0;
            frag_valid      <= 1'b0;
            frag_gen_finish <= 1'b0;
            busy            <= 1'b0;
            err             <= '0;
            remaining       <= '0;
        end else if (rst_fragment) begin
            state           <= IDLE;
            frag_x          <= '0;
            frag_y          <= '0;
            frag_valid      <= 1'b0;
            frag_gen_finish <= 1'b0;
            busy            <= 1'b0;
            err             <= '0;
            remaining       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    frag_valid      <= 1'b0;
                    frag_gen_finish <= 1'b0;
                    busy            <= 1'b0;
                    if (start_fragment) begin
                        frag_x     <= x0;
                        frag_y     <= y0;
                        err        <= err_init;
                        remaining  <= max_d;
                        frag_valid <= ok_init;
                        // A zero-length line is its own last pixel.
                        if (max_d == '0) begin
                            frag_gen_finish <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (remaining != '0) begin
                        frag_x          <= x_step;
                        frag_y          <= y_step;
                        err             <= err_step;
                        remaining       <= rem_dec;
                        frag_valid      <= ok_step;
                        frag_gen_finish <= (rem_dec == '0);
                        busy            <= (rem_dec != '0);
                        state           <= (rem_dec == '0) ? IDLE : RUN;
                    end else begin
                        frag_valid      <= 1'b0;
                        frag_gen_finish <= 1'b0;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frag_line_generator.sv
// Directed bench for frag_line_generator: table of lines with hand-computed pixel sequences
// plus hand-written sequences for restart, mid-line clear and strobe priority.
module tb_frag_line_generator;

    localparam int COORD_W = 10;
`ifdef FRAG_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               rst_fragment;
    logic               start_fragment;
    logic [COORD_W-1:0] x0, y0, dx, dy;
    logic               sx, sy;
    logic [COORD_W-1:0] frag_x, frag_y;
    logic               frag_valid, frag_gen_finish, busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [COORD_W-1:0] x0, y0, dx, dy;
        logic               sx, sy;
        int                 len;
        int                 base;
    } vec_t;

    vec_t               vecs[$];
    logic [COORD_W-1:0] exp_xq[$];
    logic [COORD_W-1:0] exp_yq[$];

    frag_line_generator #(.COORD_W(COORD_W), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk             (clk),
        .reset           (reset),
        .rst_fragment    (rst_fragment),
        .start_fragment  (start_fragment),
        .x0              (x0),
        .y0              (y0),
        .dx              (dx),
        .dy              (dy),
        .sx              (sx),
        .sy              (sy),
        .frag_x          (frag_x),
        .frag_y          (frag_y),
        .frag_valid      (frag_valid),
        .frag_gen_finish (frag_gen_finish),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input int vx0, input int vy0, input int vdx, input int vdy,
                          input int vsx, input int vsy, input int n);
        vec_t v;
        v.x0   = vx0[COORD_W-1:0];
        v.y0   = vy0[COORD_W-1:0];
        v.dx   = vdx[COORD_W-1:0];
        v.dy   = vdy[COORD_W-1:0];
        v.sx   = vsx[0];
        v.sy   = vsy[0];
        v.len  = n;
        v.base = exp_xq.size();
        vecs.push_back(v);
    endtask

    task automatic addPix(input int px, input int py);
        exp_xq.push_back(px[COORD_W-1:0]);
        exp_yq.push_back(py[COORD_W-1:0]);
    endtask

    // Starts vector idx and checks every cycle; pulse_at >= 0 re-strobes start during that pixel.
    task automatic applyStimulus(input int idx, input int pulse_at);
        vec_t               v;
        logic [COORD_W-1:0] px, py;
        logic               ev;
        v = vecs[idx];
        @(posedge clk); #1;
        x0 = v.x0; y0 = v.y0; dx = v.dx; dy = v.dy; sx = v.sx; sy = v.sy;
        start_fragment = 1'b1;
        @(posedge clk); #1;
        start_fragment = 1'b0;
        px = '0;
        py = '0;
        for (int i = 0; i < v.len; i++) begin
            px = exp_xq[v.base + i];
            py = exp_yq[v.base + i];
            ev = !CLIP || ((px < 10'd640) && (py < 10'd480));
            checkOutput($sformatf("v%0d_p%0d_x", idx, i), 32'(frag_x), 32'(px));
            checkOutput($sformatf("v%0d_p%0d_y", idx, i), 32'(frag_y), 32'(py));
            checkOutput($sformatf("v%0d_p%0d_valid", idx, i), 32'(frag_valid), 32'(ev));
            checkOutput($sformatf("v%0d_p%0d_finish", idx, i), 32'(frag_gen_finish), 32'(i == v.len - 1));
            checkOutput($sformatf("v%0d_p%0d_busy", idx, i), 32'(busy), 32'(i != v.len - 1));
            if (i == pulse_at) start_fragment = 1'b1;
            @(posedge clk); #1;
            start_fragment = 1'b0;
        end
        checkOutput($sformatf("v%0d_after_valid", idx), 32'(frag_valid), 32'd0);
        checkOutput($sformatf("v%0d_after_finish", idx), 32'(frag_gen_finish), 32'd0);
        checkOutput($sformatf("v%0d_after_busy", idx), 32'(busy), 32'd0);
        checkOutput($sformatf("v%0d_after_x", idx), 32'(frag_x), 32'(px));
        checkOutput($sformatf("v%0d_after_y", idx), 32'(frag_y), 32'(py));
    endtask

    initial begin
        reset = 1'b1; rst_fragment = 1'b0; start_fragment = 1'b0;
        x0 = '0; y0 = '0; dx = '0; dy = '0; sx = 1'b0; sy = 1'b0;

        // 0: horizontal
        addVec(0, 0, 4, 0, 0, 0, 5);
        for (int i = 0; i <= 4; i++) addPix(i, 0);
        // 1: single point
        addVec(7, 3, 0, 0, 0, 0, 1);
        addPix(7, 3);
        // 2: steep, both axes decrementing
        addVec(10, 10, 2, 5, 1, 1, 6);
        addPix(10, 10); addPix(10, 9); addPix(9, 8); addPix(9, 7); addPix(8, 6); addPix(8, 5);
        // 3: diagonal, y decrementing
        addVec(5, 5, 3, 3, 0, 1, 4);
        addPix(5, 5); addPix(6, 4); addPix(7, 3); addPix(8, 2);
        // 4: shallow
        addVec(0, 0, 8, 3, 0, 0, 9);
        addPix(0, 0); addPix(1, 0); addPix(2, 1); addPix(3, 1); addPix(4, 1);
        addPix(5, 2); addPix(6, 2); addPix(7, 3); addPix(8, 3);
        // 5: horizontal, x decrementing
        addVec(20, 2, 2, 0, 1, 0, 3);
        addPix(20, 2); addPix(19, 2); addPix(18, 2);
        // 6: crosses the right screen edge
        addVec(636, 0, 6, 0, 0, 0, 7);
        for (int i = 636; i <= 642; i++) addPix(i, 0);

        #12;
        checkOutput("reset_x", 32'(frag_x), 32'd0);
        checkOutput("reset_y", 32'(frag_y), 32'd0);
        checkOutput("reset_valid", 32'(frag_valid), 32'd0);
        checkOutput("reset_finish", 32'(frag_gen_finish), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int k = 0; k < vecs.size(); k++) applyStimulus(k, -1);

        $display("[TB] start strobe during RUN");
        applyStimulus(2, 1);
        applyStimulus(4, 3);

        $display("[TB] mid-line clear");
        @(posedge clk); #1;
        x0 = 10'd0; y0 = 10'd0; dx = 10'd8; dy = 10'd3; sx = 1'b0; sy = 1'b0;
        start_fragment = 1'b1;
        @(posedge clk); #1;
        start_fragment = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("clr_3rd_x", 32'(frag_x), 32'd2);
        checkOutput("clr_3rd_y", 32'(frag_y), 32'd1);
        checkOutput("clr_3rd_valid", 32'(frag_valid), 32'd1);
        rst_fragment = 1'b1;
        @(posedge clk); #1;
        rst_fragment = 1'b0;
        checkOutput("clr_valid", 32'(frag_valid), 32'd0);
        checkOutput("clr_busy", 32'(busy), 32'd0);
        checkOutput("clr_finish", 32'(frag_gen_finish), 32'd0);
        checkOutput("clr_x", 32'(frag_x), 32'd0);
        checkOutput("clr_y", 32'(frag_y), 32'd0);
        @(posedge clk); #1;
        checkOutput("clr_idle_valid", 32'(frag_valid), 32'd0);
        applyStimulus(4, -1);

        $display("[TB] clear and start together");
        @(posedge clk); #1;
        x0 = 10'd7; y0 = 10'd3; dx = 10'd3; dy = 10'd1; sx = 1'b0; sy = 1'b0;
        rst_fragment = 1'b1;
        start_fragment = 1'b1;
        @(posedge clk); #1;
        rst_fragment = 1'b0;
        start_fragment = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("both_c%0d_valid", i), 32'(frag_valid), 32'd0);
            checkOutput($sformatf("both_c%0d_busy", i), 32'(busy), 32'd0);
            checkOutput($sformatf("both_c%0d_finish", i), 32'(frag_gen_finish), 32'd0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
